// File: rtl/sha256_msg_packer.sv
// sha256_msg_packer: packs a byte stream into a single 55-byte SHA-256 block for the hash core
module sha256_msg_packer (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   s_data,
    input  logic         s_valid,
    input  logic         s_last,
    output logic         s_ready,
    output logic [439:0] data_in,
    output logic [5:0]   byte_valid,
    output logic         data_valid,
    output logic         msg_valid,
    input  logic         hash_done,
    output logic         overflow_err,
    output logic         busy
);
    typedef enum logic [1:0] {COLLECT, LAUNCH, WAIT, DRAIN} state_t;
    state_t       r_state;
    state_t       w_next;
    logic [439:0] r_data;
    logic [5:0]   r_count;
    logic         r_ovf;
    logic         w_acc;
    logic         w_full;
    assign w_acc  = s_valid && s_ready;
    assign w_full = r_count == 6'd55;
    // state register
    always_ff @(posedge clk) begin
        r_state <= rst ? COLLECT : w_next;
    end
    // next-state: a 56th byte overflows; with s_last it just restarts, without it drains the rest
    always_comb begin
        w_next = r_state;
        case (r_state)
            COLLECT: w_next = !w_acc ? COLLECT : !w_full ? (s_last ? LAUNCH : COLLECT) : (s_last ? COLLECT : DRAIN);
            LAUNCH:  w_next = WAIT;
            WAIT:    w_next = hash_done ? COLLECT : WAIT;
            default: w_next = (w_acc && s_last) ? COLLECT : DRAIN;
        endcase
    end
    // outputs: the block is only exposed to the core while it owns it, so partial data stays hidden
    always_comb begin
        busy         = r_state == LAUNCH || r_state == WAIT;
        s_ready      = !rst && !busy;
        msg_valid    = r_state == LAUNCH;
        data_valid   = busy;
        byte_valid   = busy ? r_count : 6'd0;
        data_in      = busy ? r_data : 440'd0;
        overflow_err = r_ovf;
    end
    // byte packing, overflow detection and release after the core finishes
    always_ff @(posedge clk) begin
        r_ovf <= 1'b0;
        if (rst) begin
            r_data  <= '0;
            r_count <= '0;
        end else if (r_state == COLLECT && w_acc && w_full) begin
            r_data  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b1;
        end else if (r_state == COLLECT && w_acc) begin
            r_data  <= r_data | ({s_data, 432'd0} >> {r_count, 3'b000});
            r_count <= r_count + 6'd1;
        end else if (r_state == WAIT && hash_done) begin
            r_data  <= '0;
            r_count <= '0;
        end
    end
endmodule

// File: tb/tb_sha256_msg_packer.sv
// tb_sha256_msg_packer: directed scenario tests for the SHA-256 message packer
module tb_sha256_msg_packer;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   s_data = '0;
    logic         s_valid = 1'b0;
    logic         s_last = 1'b0;
    logic         s_ready;
    logic [439:0] data_in;
    logic [5:0]   byte_valid;
    logic         data_valid;
    logic         msg_valid;
    logic         hash_done = 1'b0;
    logic         overflow_err;
    logic         busy;
    int n_chk = 0;
    int n_fail = 0;
    int ovf_cnt = 0;
    int msg_cnt = 0;

    sha256_msg_packer dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .data_in(data_in), .byte_valid(byte_valid), .data_valid(data_valid),
        .msg_valid(msg_valid), .hash_done(hash_done), .overflow_err(overflow_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (overflow_err) ovf_cnt++;
        if (msg_valid) msg_cnt++;
    end

    function automatic logic [439:0] pack(input int base, input int n);
        logic [439:0] v = '0;
        for (int k = 0; k < n; k++) v[439 - 8*k -: 8] = 8'(base + k);
        return v;
    endfunction

    task automatic drive(input logic [7:0] d, input logic v, input logic l);
        @(negedge clk);
        s_data = d; s_valid = v; s_last = l;
    endtask

    task automatic send(input int base, input int n, input logic last);
        for (int k = 0; k < n; k++) drive(8'(base + k), 1'b1, last && k == n - 1);
    endtask

    task automatic release_hash();
        drive(8'h00, 1'b0, 1'b0);
        hash_done = 1'b1;
        drive(8'h00, 1'b0, 1'b0);
        hash_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) drive(8'h00, 1'b0, 1'b0);
        n_chk++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready got %b exp 0", s_ready); end
        n_chk++; if ({msg_valid, busy, data_valid, overflow_err, byte_valid} !== 10'd0) begin n_fail++; $display("FAIL reset_flags got %b exp 0", {msg_valid, busy, data_valid, overflow_err, byte_valid}); end
        n_chk++; if (data_in !== 440'd0) begin n_fail++; $display("FAIL reset_data got %h exp 0", data_in); end
        rst = 1'b0;
        #1;
        n_chk++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_s_ready got %b exp 1", s_ready); end
    endtask

    task automatic test_abc();
        send(8'h61, 3, 1'b1);
        drive(8'h00, 1'b0, 1'b0);
        n_chk++; if ({msg_valid, data_valid, busy, s_ready} !== 4'b1110) begin n_fail++; $display("FAIL abc_launch_flags got %b exp 1110", {msg_valid, data_valid, busy, s_ready}); end
        n_chk++; if (byte_valid !== 6'd3) begin n_fail++; $display("FAIL abc_byte_valid got %0d exp 3", byte_valid); end
        n_chk++; if (data_in !== {24'h616263, 416'd0}) begin n_fail++; $display("FAIL abc_data got %h exp 616263 then zeros", data_in); end
        repeat (3) begin
            drive(8'h00, 1'b0, 1'b0);
            n_chk++; if ({msg_valid, busy, s_ready, byte_valid} !== {3'b010, 6'd3}) begin n_fail++; $display("FAIL abc_wait_flags got %b exp 0100000011", {msg_valid, busy, s_ready, byte_valid}); end
            n_chk++; if (data_in !== {24'h616263, 416'd0}) begin n_fail++; $display("FAIL abc_wait_data got %h", data_in); end
        end
        release_hash();
        n_chk++; if ({s_ready, data_valid, busy, byte_valid} !== {3'b100, 6'd0}) begin n_fail++; $display("FAIL abc_done_flags got %b exp 100000000", {s_ready, data_valid, busy, byte_valid}); end
        n_chk++; if (data_in !== 440'd0) begin n_fail++; $display("FAIL abc_done_data got %h exp 0", data_in); end
    endtask

    task automatic test_max55();
        send(0, 55, 1'b1);
        drive(8'h00, 1'b0, 1'b0);
        n_chk++; if ({msg_valid, overflow_err} !== 2'b10) begin n_fail++; $display("FAIL max55_flags got %b exp 10", {msg_valid, overflow_err}); end
        n_chk++; if (byte_valid !== 6'd55) begin n_fail++; $display("FAIL max55_byte_valid got %0d exp 55", byte_valid); end
        n_chk++; if (data_in[7:0] !== 8'h36 || data_in[439:432] !== 8'h00) begin n_fail++; $display("FAIL max55_ends got %h/%h exp 00/36", data_in[439:432], data_in[7:0]); end
        n_chk++; if (data_in !== pack(0, 55)) begin n_fail++; $display("FAIL max55_data got %h", data_in); end
        release_hash();
    endtask

    task automatic test_overflow_drain();
        int o0 = ovf_cnt;
        int m0 = msg_cnt;
        send(0, 56, 1'b0);
        drive(8'h00, 1'b0, 1'b0);
        n_chk++; if ({overflow_err, s_ready, busy} !== 3'b110) begin n_fail++; $display("FAIL ovf_pulse got %b exp 110", {overflow_err, s_ready, busy}); end
        drive(8'h00, 1'b0, 1'b0);
        n_chk++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL ovf_one_cycle got %b exp 0", overflow_err); end
        send(8'h80, 3, 1'b1);
        drive(8'h00, 1'b0, 1'b0);
        n_chk++; if ({msg_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL drain_no_launch got %b exp 00", {msg_valid, busy}); end
        send(8'h61, 3, 1'b1);
        drive(8'h00, 1'b0, 1'b0);
        n_chk++; if ({msg_valid, byte_valid} !== {1'b1, 6'd3}) begin n_fail++; $display("FAIL drain_abc_launch got %b exp 1000011", {msg_valid, byte_valid}); end
        n_chk++; if (data_in !== pack(8'h61, 3)) begin n_fail++; $display("FAIL drain_abc_data got %h", data_in); end
        release_hash();
        n_chk++; if (ovf_cnt - o0 !== 1) begin n_fail++; $display("FAIL ovf_count got %0d exp 1", ovf_cnt - o0); end
        n_chk++; if (msg_cnt - m0 !== 1) begin n_fail++; $display("FAIL ovf_msg_count got %0d exp 1", msg_cnt - m0); end
    endtask

    task automatic test_overflow_last();
        send(0, 55, 1'b0);
        send(8'h40, 1, 1'b1);
        drive(8'h00, 1'b0, 1'b0);
        n_chk++; if ({overflow_err, msg_valid, busy, s_ready} !== 4'b1001) begin n_fail++; $display("FAIL ovf_last_pulse got %b exp 1001", {overflow_err, msg_valid, busy, s_ready}); end
        drive(8'h00, 1'b0, 1'b0);
        n_chk++; if ({overflow_err, msg_valid} !== 2'b00) begin n_fail++; $display("FAIL ovf_last_quiet got %b exp 00", {overflow_err, msg_valid}); end
        send(8'h61, 3, 1'b1);
        drive(8'h00, 1'b0, 1'b0);
        n_chk++; if ({msg_valid, byte_valid} !== {1'b1, 6'd3}) begin n_fail++; $display("FAIL ovf_last_collect got %b exp 1000011", {msg_valid, byte_valid}); end
        release_hash();
    endtask

    task automatic test_wait_hold();
        send(8'h68, 2, 1'b1);
        drive(8'hAA, 1'b1, 1'b0);
        n_chk++; if (msg_valid !== 1'b1) begin n_fail++; $display("FAIL hold_launch got %b exp 1", msg_valid); end
        repeat (9) begin
            drive(8'hAA, 1'b1, 1'b0);
            n_chk++; if ({s_ready, data_valid, byte_valid} !== {2'b01, 6'd2} || data_in !== pack(8'h68, 2)) begin n_fail++; $display("FAIL hold_wait got %b %h", {s_ready, data_valid, byte_valid}, data_in); end
        end
        hash_done = 1'b1;
        drive(8'h00, 1'b0, 1'b0);
        hash_done = 1'b0;
        n_chk++; if ({s_ready, data_valid} !== 2'b10) begin n_fail++; $display("FAIL hold_done got %b exp 10", {s_ready, data_valid}); end
        send(8'h11, 1, 1'b1);
        drive(8'h00, 1'b0, 1'b0);
        n_chk++; if (byte_valid !== 6'd1 || data_in !== pack(8'h11, 1)) begin n_fail++; $display("FAIL hold_no_consume got %0d %h exp 1", byte_valid, data_in); end
        release_hash();
    endtask

    task automatic test_reset_mid();
        send(8'h20, 20, 1'b0);
        drive(8'h00, 1'b0, 1'b0);
        rst = 1'b1;
        drive(8'h00, 1'b0, 1'b0);
        n_chk++; if ({s_ready, msg_valid, busy, data_valid, overflow_err, byte_valid} !== 11'd0 || data_in !== 440'd0) begin n_fail++; $display("FAIL rst_mid_outputs got %b %h exp 0", {s_ready, msg_valid, busy, data_valid, overflow_err, byte_valid}, data_in); end
        rst = 1'b0;
        send(8'hFF, 1, 1'b1);
        drive(8'h00, 1'b0, 1'b0);
        n_chk++; if ({msg_valid, byte_valid} !== {1'b1, 6'd1} || data_in !== {8'hFF, 432'd0}) begin n_fail++; $display("FAIL rst_mid_ff got %b %h", {msg_valid, byte_valid}, data_in); end
        rst = 1'b1;
        drive(8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        n_chk++; if ({msg_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL rst_launch got %b exp 00", {msg_valid, busy}); end
        drive(8'h00, 1'b0, 1'b0);
        n_chk++; if ({msg_valid, busy, s_ready} !== 3'b001) begin n_fail++; $display("FAIL rst_launch_after got %b exp 001", {msg_valid, busy, s_ready}); end
        send(0, 56, 1'b0);
        drive(8'h00, 1'b0, 1'b0);
        rst = 1'b1;
        drive(8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        send(8'h61, 3, 1'b1);
        drive(8'h00, 1'b0, 1'b0);
        n_chk++; if ({msg_valid, byte_valid} !== {1'b1, 6'd3}) begin n_fail++; $display("FAIL rst_drain got %b exp 1000011", {msg_valid, byte_valid}); end
        release_hash();
    endtask

    task automatic test_gaps();
        hash_done = 1'b1;
        repeat (2) drive(8'h00, 1'b0, 1'b0);
        hash_done = 1'b0;
        n_chk++; if ({busy, s_ready, msg_valid} !== 3'b010) begin n_fail++; $display("FAIL gaps_ignore_done got %b exp 010", {busy, s_ready, msg_valid}); end
        for (int k = 0; k < 10; k++) begin
            drive(8'(8'hA0 + k), 1'b1, k == 9);
            hash_done = 1'b0;
            if (k < 9) repeat ($urandom_range(0, 2)) begin
                drive(8'h55, 1'b0, 1'b1);
                hash_done = 1'b1;
            end
        end
        drive(8'h00, 1'b0, 1'b0);
        hash_done = 1'b0;
        n_chk++; if ({msg_valid, byte_valid} !== {1'b1, 6'd10}) begin n_fail++; $display("FAIL gaps_launch got %b exp 1001010", {msg_valid, byte_valid}); end
        n_chk++; if (data_in !== pack(8'hA0, 10)) begin n_fail++; $display("FAIL gaps_data got %h", data_in); end
        release_hash();
    endtask

    initial begin
        test_reset();
        test_abc();
        test_max55();
        test_overflow_drain();
        test_overflow_last();
        test_wait_hold();
        test_reset_mid();
        test_gaps();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sha256_msg_packer.md
SHA256_MSG_PACKER -- requirements
Module: sha256_msg_packer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous to clk, active-high.
REQ-004 s_data  input  8  message byte from the upstream source.
REQ-005 s_valid  input  1  s_data is valid this cycle.
REQ-006 s_last  input  1  qualifies the current byte as the final byte of the message.
REQ-007 s_ready  output  1  the packer accepts a byte this cycle.
REQ-008 data_in  output  440  packed message for the hash core, first byte at [439:432].
REQ-009 byte_valid  output  6  message length in bytes, 1..55.
REQ-010 data_valid  output  1  data_in and byte_valid are stable and owned by the core.
REQ-011 msg_valid  output  1  one-cycle start pulse to the hash core.
REQ-012 hash_done  input  1  the hash core has finished the current message.
REQ-013 overflow_err  output  1  one-cycle pulse when a message longer than 55 bytes is dropped.
REQ-014 busy  output  1  a message is in LAUNCH or WAIT.

Function
REQ-015 A byte SHALL be accepted only on a rising edge where s_valid && s_ready.
REQ-016 Accepted byte number k (0-based) SHALL be written to data_in[439-8k -: 8], and the byte count SHALL increment by 1.
REQ-017 The FSM SHALL have the states COLLECT, LAUNCH, WAIT and DRAIN.
REQ-018 s_ready SHALL be 1 in COLLECT and DRAIN, and 0 in LAUNCH and WAIT.
REQ-019 COLLECT->LAUNCH SHALL occur on an accepted byte with s_last=1 when the count after acceptance is <= 55.
REQ-020 In LAUNCH, msg_valid SHALL be 1 for exactly one cycle, with data_valid=1 and byte_valid equal to the count; LAUNCH SHALL go to WAIT on the next edge.
REQ-021 msg_valid SHALL rise on the first edge after the s_last byte is accepted, giving 1 cycle of latency.
REQ-022 In WAIT, data_in, byte_valid and data_valid=1 SHALL be held constant until hash_done=1.
REQ-023 On hash_done=1 in WAIT, the FSM SHALL go to COLLECT on the next edge, clearing data_in to 0, byte_valid to 0, data_valid to 0 and the count to 0.
REQ-024 hash_done SHALL be ignored in COLLECT, LAUNCH and DRAIN.
REQ-025 Any data_in bits beyond byte_valid bytes SHALL be 0.
REQ-026 An accepted byte with s_last=0 that would be byte 56 SHALL be discarded, and the block SHALL:
  - pulse overflow_err for 1 cycle;
  - clear data_in and the count;
  - enter DRAIN.
REQ-027 An accepted byte with s_last=1 that would be byte 56 SHALL pulse overflow_err, clear data_in and the count, and stay in COLLECT, with no launch.
REQ-028 In DRAIN, all accepted bytes SHALL be discarded; an accepted byte with s_last=1 SHALL return the FSM to COLLECT on the next edge.
REQ-029 s_valid=0 cycles during COLLECT SHALL not alter state or count, so gaps between bytes are allowed.
REQ-030 Zero-length messages SHALL NOT be supported, and byte_valid SHALL never be 0 while msg_valid=1.
REQ-031 busy SHALL equal (state==LAUNCH || state==WAIT).

Reset
REQ-032 While rst=1 at an edge, the state SHALL become COLLECT, and the count, data_in, byte_valid, data_valid, msg_valid, overflow_err and busy SHALL be 0.
REQ-033 s_ready SHALL be 0 in any cycle where rst=1 and 1 in the first cycle after rst deasserts.
REQ-034 rst SHALL take priority over all other inputs in every state, including mid-collection, LAUNCH, WAIT and DRAIN, with no stale msg_valid afterwards.

Verification
REQ-035 Bytes 0x61,0x62,0x63 with s_last on 0x63 -> next cycle msg_valid=1, byte_valid=3, data_in[439:416]=0x616263 and all other bits 0; then busy=1 and s_ready=0 until hash_done.
REQ-036 55 bytes 0x00..0x36 with s_last on byte 55 -> byte_valid=55 (0x37), data_in[7:0]=0x36, data_in[439:432]=0x00, no overflow_err.
REQ-037 56 bytes without s_last, then 3 bytes ending in s_last, then "abc" -> overflow_err pulses once on byte 56 and no msg_valid for the long message; "abc" then launches with byte_valid=3.
REQ-038 s_valid held 1 during WAIT, hash_done asserted 10 cycles after msg_valid -> no byte consumed in WAIT; s_ready=1 and data_valid=0 on the cycle after hash_done.
REQ-039 rst asserted after 20 bytes of COLLECT -> all outputs 0 next cycle; a following 1-byte message 0xFF launches with byte_valid=1 and data_in[439:432]=0xFF.
REQ-040 hash_done pulsed in COLLECT, and a random s_valid gap pattern within a 10-byte message -> hash_done is ignored and byte_valid=10 with bytes in order.
